// File: rtl/dtw_core_minsel.sv
// Minimum-cost selector at the tail of a DTW PE array: tracks the lowest cost and its position
// over one scan. Optional saturated-sample counter enabled by defining DTW_MINSEL_SATCNT_EN.
module dtw_core_minsel #(
    parameter int width     = 16,
    parameter int pos_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_cost,
    input  logic                 in_last,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [width-1:0]     res_cost,
    output logic [pos_width-1:0] res_pos,
    output logic [pos_width-1:0] sat_count,
    output logic                 busy
);

    localparam logic [width-1:0]     COST_MAX = {width{1'b1}};
    localparam logic [pos_width-1:0] POS_ZERO = {pos_width{1'b0}};
    localparam logic [pos_width-1:0] POS_MAX  = {pos_width{1'b1}};
    localparam logic [pos_width-1:0] POS_ONE  = {{(pos_width-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [width-1:0]       best_cost_r;
    logic [pos_width-1:0]   best_pos_r;
    logic [pos_width-1:0]   pos_r;
    logic [width-1:0]       res_cost_r;
    logic [pos_width-1:0]   res_pos_r;
    logic                   accept_s;
    logic                   better_s;
    logic                   scan_start_s;

    function automatic logic [pos_width-1:0] sat_inc(input logic [pos_width-1:0] v);
        if (v == POS_MAX) begin
            return v;
        end else begin
            return v + POS_ONE;
        end
    endfunction

    // Handshake and comparison decode
    always_comb begin
        scan_start_s = (state_r == IDLE) && start;
        accept_s     = in_valid && in_ready;
        better_s     = in_cost < best_cost_r;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (in_valid && in_last) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = SCAN;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            SCAN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            HOLD: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Running minimum, position counter and captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            best_cost_r <= COST_MAX;
            best_pos_r  <= POS_ZERO;
            pos_r       <= POS_ZERO;
            res_cost_r  <= COST_MAX;
            res_pos_r   <= POS_ZERO;
        end else if (scan_start_s) begin
            best_cost_r <= COST_MAX;
            best_pos_r  <= POS_ZERO;
            pos_r       <= POS_ZERO;
        end else if (accept_s) begin
            if (better_s) begin
                best_cost_r <= in_cost;
                best_pos_r  <= pos_r;
            end
            pos_r <= sat_inc(pos_r);
            // The last sample is folded into the captured result directly.
            if (in_last) begin
                res_cost_r <= better_s ? in_cost : best_cost_r;
                res_pos_r  <= better_s ? pos_r : best_pos_r;
            end
        end
    end

    assign res_cost = res_cost_r;
    assign res_pos  = res_pos_r;

`ifdef DTW_MINSEL_SATCNT_EN
    logic [pos_width-1:0] sat_count_r;

    // Count accepted samples pinned at the cost ceiling
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_r <= POS_ZERO;
        end else if (scan_start_s) begin
            sat_count_r <= POS_ZERO;
        end else if (accept_s && (in_cost == COST_MAX)) begin
            sat_count_r <= sat_inc(sat_count_r);
        end
    end

    assign sat_count = sat_count_r;
`else
    assign sat_count = POS_ZERO;
`endif

endmodule

// File: doc/dtw_core_minsel.md
DTW_CORE_MINSEL -- requirements
Module: dtw_core_minsel

Interface
REQ-001 SHALL have parameter width, default 16, the DTW cost width; it matches the PE's cost width.
REQ-002 SHALL have parameter pos_width, default 32, the reference position counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a new scan.
REQ-006 SHALL have port in_valid, input, 1, meaning in_cost is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, high when the block accepts cost samples.
REQ-008 SHALL have port in_cost, input, width, the DTW cost from the last PE of the array.
REQ-009 SHALL have port in_last, input, 1, marking the final cost sample of the scan.
REQ-010 SHALL have port res_valid, output, 1, meaning the result is available.
REQ-011 SHALL have port res_ready, input, 1, the result consumer acknowledge.
REQ-012 SHALL have port res_cost, output, width, the minimum cost seen.
REQ-013 SHALL have port res_pos, output, pos_width, the position of the minimum cost.
REQ-014 SHALL have port sat_count, output, pos_width, the count of saturated samples.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, SCAN and HOLD.
REQ-017 SHALL react to start only in IDLE; a start there moves the block to SCAN next cycle and clears the scan state:
- best cost to all-ones
- best position to 0
- position counter to 0
- sat_count to 0
REQ-018 SHALL ignore start in SCAN and HOLD.
REQ-019 SHALL drive in_ready high only in SCAN.
REQ-020 SHALL accept a sample only when in_valid and in_ready are both high; in_valid in IDLE or HOLD has no effect.
REQ-021 SHALL, on each accepted sample, take in_cost as the new best cost and the current position as the new best position when in_cost is strictly less than the best cost.
REQ-022 SHALL keep the earliest position on ties.
REQ-023 SHALL increment the position counter after every accepted sample, saturating at all-ones with no wrap.
REQ-024 SHALL include the sample accepted with in_last in the minimum, then enter HOLD on the next cycle.
REQ-025 SHALL assert res_valid exactly one cycle after the in_last sample is accepted.
REQ-026 SHALL hold res_valid, res_cost, res_pos and sat_count stable in HOLD until res_valid and res_ready are both high.
REQ-027 SHALL, on that handshake, return to IDLE with res_valid low on the next cycle.
REQ-028 SHALL keep res_cost and res_pos holding their last values in IDLE, with res_valid low.
REQ-029 SHALL ignore a start in the same cycle as the HOLD handshake; a new scan needs at least one cycle in IDLE.
REQ-030 SHALL report res_cost all-ones and res_pos 0 when every sample equals all-ones.
REQ-031 SHALL perform all comparisons unsigned at width bits.
REQ-032 SHALL drive in_ready from state only, with no combinational path from any input.

Reset
REQ-033 SHALL, while rst is high at a clock edge, force:
- state to IDLE
- res_valid, in_ready and busy to 0
- res_cost to all-ones
- res_pos, sat_count and the position counter to 0
REQ-034 SHALL abandon a scan or HOLD when rst asserts mid-operation, with no result produced.
REQ-035 SHALL give rst priority over start, in_valid and res_ready.

Configuration
REQ-036 SHALL, with DTW_MINSEL_SATCNT_EN defined, increment sat_count (saturating) for each accepted sample equal to all-ones.
REQ-037 SHALL, without DTW_MINSEL_SATCNT_EN, tie sat_count to 0, keep the port present, and compile no counter logic.

Verification
REQ-038 SHALL cover: start, then costs 9,4,7,4,2(last) with in_valid every cycle -> res_cost 2, res_pos 4, res_valid one cycle after the last sample.
REQ-039 SHALL cover: costs 5,3,3,8(last) -> res_pos 1, confirming the earliest tie is kept.
REQ-040 SHALL cover: costs FFFF,FFFF,FFFF(last) at width 16 -> res_cost FFFF, res_pos 0, sat_count 3 with the macro and 0 without it.
REQ-041 SHALL cover: res_ready held low 5 cycles in HOLD, with in_valid and start toggled meanwhile -> outputs stable, then IDLE one cycle after res_ready goes high.
REQ-042 SHALL cover: rst pulsed after 2 of 6 samples, then start and 3 new samples 6,1,9(last) -> res_cost 1, res_pos 1.
REQ-043 SHALL cover: in_valid gaps of 1-3 cycles between 4 samples 8,6,7,5(last) -> res_pos 3, so gaps do not advance the position.
